alu_result_sender: RTL and testbench
====================================

Name: alu_result_sender

Overview:
- Output-side counterpart of the switch/button operand loader.
- On a start pulse, captures the ALU result and the operation code that produced it.
- Streams them out as a byte frame to the UART transmitter over a valid/ready handshake.
- Sits between the ALU outputs and the UART TX block in the top-level.

Parameters:
- NB_DATA, 8, width of the ALU result; must be a multiple of NB_BYTE.
- NB_OP, 6, width of the operation code; must be ≤ NB_BYTE.
- NB_BYTE, 8, width of one transmitted byte.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  reset; synchronous, active-high; clock i_clock.
- i_start  in  1  single-cycle request to capture and send a frame.
- i_result  in  NB_DATA  signed ALU result.
- i_operation  in  NB_OP  operation code currently applied to the ALU.
- i_tx_ready  in  1  transmitter can accept a byte this cycle.
- o_tx_data  out  NB_BYTE  byte being offered.
- o_tx_valid  out  1  o_tx_data is valid.
- o_busy  out  1  frame in progress (any state except IDLE).
- o_done  out  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset: state=IDLE; o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0; capture registers and byte counter cleared.
- Frame, in this order:
  - op byte: i_operation zero-extended to NB_BYTE.
  - NB_DATA/NB_BYTE result bytes, least-significant byte first.
- Capture:
  - i_start high in IDLE at edge N latches i_result and i_operation.
  - Later changes on these inputs do not affect the frame in progress.
- Latency: o_tx_valid=1 with the op byte from cycle N+1.
- Handshake:
  - A byte is transferred on a rising edge where o_tx_valid && i_tx_ready.
  - o_tx_data and o_tx_valid are held stable until that transfer.
  - The next byte, if any, is presented the cycle immediately after the transfer; no idle gap is required.
- FSM:
  - IDLE -> SEND_OP on i_start.
  - SEND_OP -> SEND_RES on transfer.
  - SEND_RES loops with the byte counter 0..NB_DATA/NB_BYTE-1.
  - SEND_RES -> DONE on the last transfer.
  - DONE -> IDLE unconditionally after one cycle; o_done=1 only in DONE.
  - o_tx_valid=0 in IDLE and DONE.
- i_start while not IDLE, including the DONE cycle, is ignored; there is no queuing.
- i_tx_ready low indefinitely: the block stalls in the current state with outputs held and no timeout.
- i_tx_ready high while o_tx_valid low: no effect.
- Reset mid-frame: returns to IDLE on that edge; the partial frame is abandoned; o_done is not asserted.
- Byte counter wraps to 0 on leaving SEND_RES.

Optional Feature:
- Macro: RESULT_CHECKSUM_EN.
- Defined:
  - Adds state SEND_CHK after SEND_RES.
  - SEND_CHK sends one extra byte: XOR of all previously sent bytes in the frame.
  - DONE follows acceptance of the checksum byte.
- Undefined:
  - No checksum byte; SEND_RES goes directly to DONE.
  - Neither the checksum register nor the SEND_CHK state exist in the netlist.

Decomposition:
- Shared package alu_pkg:
  - FSM state typedef/localparams: IDLE, SEND_OP, SEND_RES, SEND_CHK, DONE.
  - Default NB_DATA/NB_OP/NB_BYTE constants.
  - Operation-code constants shared with the ALU and loader.
- One natural sub-module: byte_slicer.
  - Combinational; selects result byte[index] from the captured word.
  - Also usable by a future multi-byte receiver.
- FSM and handshake stay in the top module.

Test Plan:
- Reset then idle, i_tx_ready=1 -> o_tx_valid, o_busy, o_done stay 0 for 20 cycles.
- NB_DATA=8, i_operation=6'h20, i_result=8'hF3, i_start pulse, i_tx_ready=1 ->
  - op byte 0x20 at N+1, then 0xF3 at N+2.
  - o_done pulses at N+3; o_busy low at N+4.
  - With RESULT_CHECKSUM_EN: extra byte 0xD3 at N+3 and o_done at N+4.
- Same frame with i_tx_ready low 5 cycles per byte -> data/valid held stable; byte order and values unchanged; no duplicates.
- Change i_result to 8'h00 and pulse i_start mid-frame -> frame still carries 0xF3; second start ignored; exactly one o_done.
- NB_DATA=16, i_result=16'h1234, i_operation=6'h22 -> bytes 0x22, 0x34, 0x12 in order.
- Assert i_reset after the op byte is accepted -> next cycle IDLE with all outputs 0; a fresh i_start yields a complete new frame.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg: shared FSM states, widths and ALU operation codes        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;
  localparam int NB_BYTE_DEF = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_OP  = 3'd1,
    SEND_RES = 3'd2,
    SEND_CHK = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;

  // Index width that stays legal when a word is a single byte.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_sender_byte_slicer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | byte_slicer: combinational pick of byte[i_index] from a word      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module byte_slicer #(
  parameter int NB_DATA = 8,
  parameter int NB_BYTE = 8,
  parameter int NB_IDX  = 1
) (
  input  logic [NB_DATA-1:0] i_word,
  input  logic [NB_IDX-1:0]  i_index,
  output logic [NB_BYTE-1:0] o_byte
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;

  always_comb begin
    o_byte = '0;
    for (int k = 0; k < N_BYTES; k++) begin
      if (i_index == NB_IDX'(k)) begin
        o_byte = i_word[k*NB_BYTE +: NB_BYTE];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_sender.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_result_sender: streams {op, result bytes LSB first} to UART   |
// | TX. Optional macro RESULT_CHECKSUM_EN appends an XOR byte.        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module alu_result_sender
  import alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int NB_BYTE = NB_BYTE_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_OP-1:0]   i_operation,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done
);

  localparam int                N_BYTES  = NB_DATA / NB_BYTE;
  localparam int                NB_IDX   = idx_width(N_BYTES);
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [NB_DATA-1:0]   r_result;
  logic [NB_OP-1:0]     r_op;
  logic [NB_IDX-1:0]    r_idx;
  logic [NB_BYTE-1:0]   w_slice;
  logic [NB_BYTE-1:0]   w_data;
  logic                 w_valid;
  logic                 w_xfer;
  logic                 w_capture;
`ifdef RESULT_CHECKSUM_EN
  logic [NB_BYTE-1:0]   r_chk;
`endif

  assign w_capture = (r_state == IDLE) && i_start;
  assign w_xfer    = w_valid && i_tx_ready;

  byte_slicer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE),
    .NB_IDX  (NB_IDX)
  ) u_slicer (
    .i_word  (r_result),
    .i_index (r_idx),
    .o_byte  (w_slice)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are decoded from registered state, so they hold while stalled.
  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_data  = '0;
    case (r_state)
      IDLE: begin
        if (i_start) w_next = SEND_OP;
      end
      SEND_OP: begin
        w_valid = 1'b1;
        w_data  = NB_BYTE'(r_op);
        if (i_tx_ready) w_next = SEND_RES;
      end
      SEND_RES: begin
        w_valid = 1'b1;
        w_data  = w_slice;
        if (i_tx_ready && (r_idx == LAST_IDX)) begin
`ifdef RESULT_CHECKSUM_EN
          w_next = SEND_CHK;
`else
          w_next = DONE;
`endif
        end
      end
`ifdef RESULT_CHECKSUM_EN
      SEND_CHK: begin
        w_valid = 1'b1;
        w_data  = r_chk;
        if (i_tx_ready) w_next = DONE;
      end
`endif
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_result <= '0;
      r_op     <= '0;
      r_idx    <= '0;
`ifdef RESULT_CHECKSUM_EN
      r_chk    <= '0;
`endif
    end else if (w_capture) begin
      r_result <= i_result;
      r_op     <= i_operation;
      r_idx    <= '0;
`ifdef RESULT_CHECKSUM_EN
      r_chk    <= '0;
`endif
    end else if (w_xfer) begin
      if (r_state == SEND_RES) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + NB_IDX'(1);
      end
`ifdef RESULT_CHECKSUM_EN
      r_chk <= r_chk ^ w_data;
`endif
    end
  end

  assign o_tx_data  = w_data;
  assign o_tx_valid = w_valid;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_result_sender.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_result_sender: table vectors plus random frames on 8- and  |
// | 16-bit instances. Rev 1.0                                         |
// +------------------------------------------------------------------+
module tb_alu_result_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        rdy = 1'b0;
  logic [5:0]  opr = '0;
  logic [15:0] resv = '0;

  logic [7:0] d8, d16, data;
  logic       v8, v16, valid;
  logic       b8, b16, busy;
  logic       dn8, dn16, done;
  logic       start8, start16;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign start8  = start & ~sel;
  assign start16 = start & sel;
  assign data    = sel ? d16  : d8;
  assign valid   = sel ? v16  : v8;
  assign busy    = sel ? b16  : b8;
  assign done    = sel ? dn16 : dn8;

  alu_result_sender u_dut8 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start8),
    .i_result    (resv[7:0]),
    .i_operation (opr),
    .i_tx_ready  (rdy),
    .o_tx_data   (d8),
    .o_tx_valid  (v8),
    .o_busy      (b8),
    .o_done      (dn8)
  );

  alu_result_sender #(.NB_DATA(16)) u_dut16 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start16),
    .i_result    (resv),
    .i_operation (opr),
    .i_tx_ready  (rdy),
    .o_tx_data   (d16),
    .o_tx_valid  (v16),
    .o_busy      (b16),
    .o_done      (dn16)
  );

  typedef struct {
    bit          wide;
    logic [5:0]  op;
    logic [15:0] res;
    int          mode;     // 0: ready always, 1: 5-cycle stall per byte, 2: random
    bit          disturb;  // restart + scramble inputs during the frame
    int          nexp;
    logic [7:0]  e0, e1, e2;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_chk();
`ifdef RESULT_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
  endfunction

  // Frame model: op byte, then result bytes least significant first.
  function automatic void model_frame(input bit wide, input logic [5:0] op, input logic [15:0] res);
    int nb = wide ? 2 : 1;
    exp_q.delete();
    exp_q.push_back({2'b00, op});
    for (int k = 0; k < nb; k++) exp_q.push_back(8'((res >> (8 * k)) & 16'h00FF));
    add_chk();
  endfunction

  task automatic run_frame(input bit wide, input logic [5:0] op, input logic [15:0] res,
                           input int mode, input bit disturb);
    int         idx = 0;
    int         cyc = 1;
    int         stall = 0;
    int         last_x = 0;
    bit         hold = 0;
    bit         fin = 0;
    logic [7:0] pdata = '0;
    sel = wide;
    @(negedge clk);
    opr = op; resv = res; start = 1'b1; rdy = (mode != 1);
    @(posedge clk); #1;
    start = disturb;
    check("op_latency_valid", {31'd0, valid}, 1);
    while (!fin && cyc < 500) begin
      if (disturb) begin
        resv = 16'($urandom);
        opr  = 6'($urandom);
      end
      if (hold) begin
        check("hold_valid", {31'd0, valid}, 1);
        check("hold_data", {24'd0, data}, {24'd0, pdata});
      end
      if (done) begin
        check("done_after_last_byte", idx, exp_q.size());
        check("done_cycle", cyc, last_x);
        check("done_valid_low", {31'd0, valid}, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("post_done_busy", {31'd0, busy}, 0);
        check("post_done_done", {31'd0, done}, 0);
        check("post_done_valid", {31'd0, valid}, 0);
        check("post_done_data", {24'd0, data}, 0);
        fin = 1;
      end else begin
        check("busy_in_frame", {31'd0, busy}, 1);
        check("valid_in_frame", {31'd0, valid}, 1);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (stall >= 5);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        if (rdy && valid) begin
          if (idx < exp_q.size()) begin
            check($sformatf("byte%0d", idx), {24'd0, data}, {24'd0, exp_q[idx]});
          end else begin
            n_cmp++; n_err++;
            $display("FAIL extra_byte: got %0h expected none", data);
          end
          idx++; last_x = cyc + 1; stall = 0; hold = 0;
        end else begin
          stall++; hold = valid; pdata = data;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!fin) begin
      n_cmp++; n_err++;
      $display("FAIL frame_timeout: got no o_done expected o_done within 500 cycles");
      start = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{0, 6'h20, 16'h00F3, 0, 0, 2, 8'h20, 8'hF3, 8'h00};
    tbl[1] = '{0, 6'h20, 16'h00F3, 1, 0, 2, 8'h20, 8'hF3, 8'h00};
    tbl[2] = '{0, 6'h20, 16'h00F3, 0, 1, 2, 8'h20, 8'hF3, 8'h00};
    tbl[3] = '{1, 6'h22, 16'h1234, 0, 0, 3, 8'h22, 8'h34, 8'h12};
    tbl[4] = '{1, 6'h22, 16'h1234, 1, 1, 3, 8'h22, 8'h34, 8'h12};
    tbl[5] = '{0, 6'h3F, 16'h0080, 2, 0, 2, 8'h3F, 8'h80, 8'h00};
    tbl[6] = '{1, 6'h00, 16'hFFFF, 2, 1, 3, 8'h00, 8'hFF, 8'hFF};

    // Reset state
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_data", {24'd0, data}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with ready high: nothing happens
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_valid", {31'd0, valid}, 0);
      check("idle_busy", {31'd0, busy}, 0);
      check("idle_done", {31'd0, done}, 0);
    end

    for (int t = 0; t < 7; t++) begin
      exp_q.delete();
      exp_q.push_back(tbl[t].e0);
      exp_q.push_back(tbl[t].e1);
      if (tbl[t].nexp > 2) exp_q.push_back(tbl[t].e2);
      add_chk();
      run_frame(tbl[t].wide, tbl[t].op, tbl[t].res, tbl[t].mode, tbl[t].disturb);
    end

    // Reset just after the op byte is accepted
    sel = 1'b0;
    @(negedge clk);
    opr = 6'h20; resv = 16'h00F3; start = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rstmid_op", {24'd0, data}, 32'h20);
    @(posedge clk); #1;
    check("rstmid_res_valid", {31'd0, valid}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_valid", {31'd0, valid}, 0);
    check("rstmid_busy", {31'd0, busy}, 0);
    check("rstmid_done", {31'd0, done}, 0);
    check("rstmid_data", {24'd0, data}, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstmid_no_done", {31'd0, done}, 0);
    end
    model_frame(0, 6'h25, 16'h005A);
    run_frame(0, 6'h25, 16'h005A, 0, 0);

    // Random frames against the model
    for (int r = 0; r < 30; r++) begin
      bit          w  = 1'($urandom_range(0, 1));
      logic [5:0]  op = 6'($urandom);
      logic [15:0] rs = 16'($urandom);
      bit          ds = 1'($urandom_range(0, 1));
      model_frame(w, op, rs);
      run_frame(w, op, rs, 2, ds);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
